hsv_color_arbiter: RTL

- Shares one hsv2rgb colour-conversion pipeline between NREQ requesters, e.g. per-trace colour generators in the Lissajous renderer.
- Arbitrates round-robin and drives the converter's h/s/v/ready_i inputs.
- Tracks the requester ID of each in-flight conversion and returns each result tagged with its ID.
- Checks that the converter's valid_o returns exactly LATENCY cycles after each issue.

---
 rtl/hsv_color_arbiter.sv | 176 +++++++++++++++++
 1 files changed

// File: rtl/hsv_color_arbiter.sv
// ----------------------------------------------------------------------------
// hsv_color_arbiter
//
// Shares a single hsv2rgb conversion pipeline between NREQ requesters.
// A round-robin arbiter picks one requester per cycle, registers its h/s/v
// operands towards the converter, and remembers which requester each
// in-flight conversion belongs to. Results coming back from the converter
// are returned tagged with that requester ID. The converter is expected to
// answer exactly LATENCY cycles after each issue; any disagreement between
// the converter's valid and the expected tag raises a sticky error flag.
//
// Ports:
//   clock, reset            rising-edge clock, asynchronous active-high reset
//   en_i                    issue enable (0 = no new grants)
//   req_i[NREQ]             request levels, held until acked
//   h_i/s_i/v_i[8*NREQ]     operands, requester i at [8i+7:8i]
//   ack_o[NREQ]             combinational one-hot grant
//   hsv_h/s/v_o, hsv_ready_o  registered operands and issue strobe to converter
//   hsv_r/g/b_i, hsv_valid_i  converter results
//   rsp_valid_o, rsp_id_o, rsp_r/g/b_o  registered tagged result
//   err_o                   sticky protocol-error flag
// ----------------------------------------------------------------------------
module hsv_color_arbiter #(
    parameter int  NREQ    = 4,
    parameter int  LATENCY = 2,
    localparam int IDW     = (NREQ > 2) ? $clog2(NREQ) : 1
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              en_i,
    input  logic [NREQ-1:0]   req_i,
    input  logic [8*NREQ-1:0] h_i,
    input  logic [8*NREQ-1:0] s_i,
    input  logic [8*NREQ-1:0] v_i,
    output logic [NREQ-1:0]   ack_o,
    output logic [7:0]        hsv_h_o,
    output logic [7:0]        hsv_s_o,
    output logic [7:0]        hsv_v_o,
    output logic              hsv_ready_o,
    input  logic [7:0]        hsv_r_i,
    input  logic [7:0]        hsv_g_i,
    input  logic [7:0]        hsv_b_i,
    input  logic              hsv_valid_i,
    output logic              rsp_valid_o,
    output logic [IDW-1:0]    rsp_id_o,
    output logic [7:0]        rsp_r_o,
    output logic [7:0]        rsp_g_o,
    output logic [7:0]        rsp_b_o,
    output logic              err_o
);

    localparam logic [IDW:0]   NREQ_W  = (IDW+1)'(NREQ);
    localparam logic [IDW-1:0] LAST_ID = IDW'(NREQ - 1);

    // Round-robin state: the index scanned first on the next arbitration.
    logic [IDW-1:0] ptr_reg;
    logic [IDW-1:0] ptr_next;

    // Arbitration results.
    logic           grant_found;
    logic           grant_valid;
    logic [IDW-1:0] grant_id;
    logic [IDW:0]   cand;

    // Per-requester operand views of the packed input buses.
    logic [7:0] h_arr [NREQ];
    logic [7:0] s_arr [NREQ];
    logic [7:0] v_arr [NREQ];

    // ID of the conversion currently presented on hsv_ready_o.
    logic [IDW-1:0] issue_id_reg;

    // Tag pipeline; the last entry is the result expected this cycle.
    logic           tag_valid_reg [LATENCY];
    logic [IDW-1:0] tag_id_reg    [LATENCY];
    logic           tail_valid;
    logic [IDW-1:0] tail_id;

    genvar gi;
    generate
        for (gi = 0; gi < NREQ; gi++) begin : g_req
            assign h_arr[gi] = h_i[8*gi +: 8];
            assign s_arr[gi] = s_i[8*gi +: 8];
            assign v_arr[gi] = v_i[8*gi +: 8];
            assign ack_o[gi] = grant_valid && (grant_id == IDW'(gi));
        end
    endgenerate

    // Scan requesters starting at the pointer, wrapping at NREQ-1. The loop
    // runs from the farthest offset down so the nearest set bit wins.
    always_comb begin
        grant_found = 1'b0;
        grant_id    = '0;
        cand        = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            cand = {1'b0, ptr_reg} + (IDW+1)'(k);
            if (cand >= NREQ_W) begin
                cand = cand - NREQ_W;
            end
            if (req_i[cand[IDW-1:0]]) begin
                grant_found = 1'b1;
                grant_id    = cand[IDW-1:0];
            end
        end
    end

    assign grant_valid = en_i && grant_found;
    assign ptr_next    = (grant_id == LAST_ID) ? '0 : grant_id + IDW'(1);

    assign tail_valid  = tag_valid_reg[LATENCY-1];
    assign tail_id     = tag_id_reg[LATENCY-1];

    // Arbitration pointer and converter issue registers.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            ptr_reg      <= '0;
            hsv_ready_o  <= 1'b0;
            hsv_h_o      <= '0;
            hsv_s_o      <= '0;
            hsv_v_o      <= '0;
            issue_id_reg <= '0;
        end else begin
            hsv_ready_o <= grant_valid;
            if (grant_valid) begin
                ptr_reg      <= ptr_next;
                hsv_h_o      <= h_arr[grant_id];
                hsv_s_o      <= s_arr[grant_id];
                hsv_v_o      <= v_arr[grant_id];
                issue_id_reg <= grant_id;
            end
        end
    end

    // Tag shift register, aligned so that the tail lines up with the
    // converter's valid for the same conversion.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int k = 0; k < LATENCY; k++) begin
                tag_valid_reg[k] <= 1'b0;
                tag_id_reg[k]    <= '0;
            end
        end else begin
            tag_valid_reg[0] <= hsv_ready_o;
            tag_id_reg[0]    <= issue_id_reg;
            for (int k = 1; k < LATENCY; k++) begin
                tag_valid_reg[k] <= tag_valid_reg[k-1];
                tag_id_reg[k]    <= tag_id_reg[k-1];
            end
        end
    end

    // Response and protocol checking. A result is only forwarded when the
    // converter and the tag pipeline agree; any disagreement latches err_o.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rsp_valid_o <= 1'b0;
            rsp_id_o    <= '0;
            rsp_r_o     <= '0;
            rsp_g_o     <= '0;
            rsp_b_o     <= '0;
            err_o       <= 1'b0;
        end else begin
            rsp_valid_o <= hsv_valid_i && tail_valid;
            if (hsv_valid_i && tail_valid) begin
                rsp_id_o <= tail_id;
                rsp_r_o  <= hsv_r_i;
                rsp_g_o  <= hsv_g_i;
                rsp_b_o  <= hsv_b_i;
            end
            if (hsv_valid_i != tail_valid) begin
                err_o <= 1'b1;
            end
        end
    end

endmodule
